button_debounce_pulse: RTL
==========================

// Module: button_debounce_pulse
// PURPOSE
//  Conditions a raw, bouncing, asynchronous push-button (BTN) into clean single-cycle
//  event strobes in the clk domain. It sits directly upstream of the N-digit BCD counter
//  and 7-segment display stage, which uses press_pulse as its count enable.
//  It provides an optional auto-repeat while the button is held.
// PARAMETERS
//  SYNC_STAGES      2        flops in the input synchronizer chain (>=2)
//  DEBOUNCE_CYCLES  1000000  consecutive stable samples needed to accept a level change (>=2)
//  REPEAT_EN        1        1 = auto-repeat press_pulse while held; 0 = single pulse per press
//  REPEAT_DELAY     50000000 cycles from the initial press pulse to the first repeat pulse (>=2)
//  REPEAT_PERIOD    10000000 cycles between successive repeat pulses (>=2)
//  CNT_WIDTH        26       width of the internal counters; must hold every count above
// PORTS
//  clk            in   1  system clock; all logic on the rising edge
//  rst            in   1  reset, asynchronous, active-low
//  en             in   1  1 = strobes enabled; 0 = press_pulse/release_pulse forced 0 (FSM still runs)
//  BTN            in   1  raw button, asynchronous to clk, bouncing
//  btn_level      out  1  debounced button level
//  press_pulse    out  1  1-cycle strobe on an accepted press and on each auto-repeat
//  release_pulse  out  1  1-cycle strobe on an accepted release
// BEHAVIOUR
//  - Reset (rst=0): sync chain=0, state=IDLE, counters=0, all outputs 0, applied immediately.
//    A button already held when rst deasserts is treated as a new press.
//  - s = last synchronizer flop. All decisions use s only; BTN is never used directly.
//  - All outputs are registered. press_pulse and release_pulse are never high in the same cycle.
//  - FSM:
//    IDLE: btn_level=0. s=1 -> ARMING, with cnt counting this as sample 1.
//    ARMING: s=0 -> IDLE, no pulse (glitch rejected).
//      s=1 on the DEBOUNCE_CYCLES-th consecutive sample -> HELD.
//      On that same edge: btn_level<=1, press_pulse<=1 (if en), rep_cnt<=0.
//    HELD: btn_level=1. s=0 -> RELEASING, counting this as sample 1.
//      If REPEAT_EN: press_pulse (if en) fires at edges P+REPEAT_DELAY and
//      P+REPEAT_DELAY+k*REPEAT_PERIOD, where P is the initial press edge.
//    RELEASING: btn_level stays 1 and no repeats fire.
//      s=1 -> HELD, no pulse, repeat timing restarts (rep_cnt<=0).
//      s=0 on the DEBOUNCE_CYCLES-th consecutive sample -> IDLE.
//      On that same edge: btn_level<=0, release_pulse<=1 (if en).
//  - Latency: BTN changing just after edge E0 -> output change on edge
//    E(SYNC_STAGES+DEBOUNCE_CYCLES). Each strobe is high for exactly 1 cycle.
//  - Counters saturate and never wrap inside a state. Both counters clear on every state change.
//  - en is sampled on the pulse edge. An event suppressed by en=0 is lost, not queued.
//    btn_level ignores en.
// TESTING  (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, REPEAT_EN=1, en=1)
//  1 Clean press: BTN 0->1 just after E0, held.
//    -> btn_level and press_pulse rise at E6; press_pulse is 0 again at E7. No release_pulse.
//  2 Glitch: BTN high for 3 cycles, then low.
//    -> no press_pulse, btn_level stays 0, FSM returns to IDLE.
//  3 Bounce: BTN toggles 1,0,1,0,1 (1 cycle each), then stays 1 from E10.
//    -> exactly one press_pulse, at E16.
//  4 Auto-repeat: press as in test 1, hold, release BTN just after E50.
//    -> press_pulse at E6, E26, E34, E42, E50.
//    -> btn_level falls and release_pulse fires at E56. No pulse at E58.
//  5 Reset mid-HELD: rst=0 at E30 while BTN=1.
//    -> outputs 0 immediately. After rst=1, press_pulse fires again after 2+4 edges.
//  6 en=0 during the press of test 1.
//    -> btn_level rises at E6, press_pulse stays 0. Setting en=1 later gives no late pulse.

Source files
------------

// File: rtl/button_debounce_pulse.sv
// Push-button conditioner: synchronizes a raw, bouncing button into the clk domain,
// debounces it and turns accepted edges into single-cycle press/release strobes,
// with an optional auto-repeat of press_pulse while the button stays held.
// The FSM state is brought out on fsm_state so checkers can follow it.
module button_debounce_pulse #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int CNT_WIDTH       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       BTN,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } state_t;

  // Counters compare against "last sample/edge" values: a state is entered with the
  // count already reflecting the edge that caused the entry.
  localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DLY_LAST = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] PER_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   rep_cnt;
  logic                   rep_phase;  // 0: waiting for first repeat, 1: periodic repeats
  logic [CNT_WIDTH-1:0]   rep_last;

  assign s         = sync_q[SYNC_STAGES-1];
  assign rep_last  = rep_phase ? PER_LAST : DLY_LAST;
  assign fsm_state = state;

  // Synchronizer chain: the raw button only ever enters through here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], BTN};
    end
  end

  // Debounce/repeat FSM with registered level and strobe outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      rep_cnt       <= '0;
      rep_phase     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          btn_level <= 1'b0;
          if (s) begin
            state   <= ARMING;
            cnt     <= CNT_ONE;
            rep_cnt <= '0;
          end
        end
        ARMING: begin
          if (!s) begin
            // Too short to be a press: drop it silently.
            state   <= IDLE;
            cnt     <= '0;
            rep_cnt <= '0;
          end else if (cnt >= DEB_LAST) begin
            state       <= HELD;
            btn_level   <= 1'b1;
            press_pulse <= en;
            cnt         <= '0;
            rep_cnt     <= '0;
            rep_phase   <= 1'b0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!s) begin
            state   <= RELEASING;
            cnt     <= CNT_ONE;
            rep_cnt <= '0;
          end else if (REPEAT_EN != 0 && rep_cnt >= rep_last) begin
            press_pulse <= en;
            rep_cnt     <= '0;
            rep_phase   <= 1'b1;
          end else if (rep_cnt != '1) begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
        RELEASING: begin
          if (s) begin
            // Bounce back to held: no strobe, repeat schedule starts over.
            state     <= HELD;
            cnt       <= '0;
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
          end else if (cnt >= DEB_LAST) begin
            state         <= IDLE;
            btn_level     <= 1'b0;
            release_pulse <= en;
            cnt           <= '0;
            rep_cnt       <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
